// File: rtl/axis_upsizer.sv
// axis_upsizer: packs a narrow AXI-Stream byte stream into RATIO-lane words.
// Lane 0 carries the first byte of each word. m_keep marks the filled lanes of a
// short tail word, and pkt_cnt counts the packets delivered downstream.
module axis_upsizer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4,
    parameter int OUT_W = IN_W * RATIO
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [OUT_W-1:0] m_data,
    output logic [RATIO-1:0] m_keep,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [15:0]      pkt_cnt
);

    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] acc;
    logic [RATIO-1:0] acc_keep;
    logic [OUT_W-1:0] word_next;
    logic [RATIO-1:0] keep_next;
    logic             accept;
    logic             complete;
    logic             drain;

    // The input is held off only while a finished word is waiting on the output,
    // so the accumulator cannot overrun a word that has not been taken yet.
    assign s_ready  = resetn & (~m_valid | m_ready);
    assign accept   = s_valid & s_ready;
    assign complete = accept & ((idx == IDX_W'(RATIO - 1)) | s_last);
    assign drain    = m_valid & m_ready;

    // Merge the incoming byte into its lane of the partial word. Lanes above idx
    // are still zero, which is what makes unused lanes of a short word read 0.
    always_comb begin
        word_next = acc;
        keep_next = acc_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (idx == IDX_W'(i)) begin
                word_next[i*IN_W +: IN_W] = s_data;
                keep_next[i]              = 1'b1;
            end
        end
    end

    // Lane index and partial-word accumulator. A completed word clears both so
    // the next byte always lands in lane 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx      <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else if (complete) begin
            idx      <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            idx      <= idx + IDX_W'(1);
            acc      <= word_next;
            acc_keep <= keep_next;
        end
    end

    // Output word register. A word completing in the same cycle as a drain
    // replaces the old word directly, so back-to-back words have no bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (complete) begin
            m_data  <= word_next;
            m_keep  <= keep_next;
            m_last  <= s_last;
            m_valid <= 1'b1;
        end else if (drain) begin
            m_valid <= 1'b0;
        end
    end

    // Count delivered packets; the 16-bit counter wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt <= '0;
        end else if (drain && m_last) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule
